// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: byte width, link
// configuration and the arbiter state encoding.
package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;
  localparam int BAUD_RATE       = 9600;
  localparam int CLK_FREQ        = 100_000_000;

  // Arbiter sequencing states; the encoding is visible on the debug port.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_END       = 3'd4,
    ST_NEXT      = 3'd5
  } state_e;

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin pick: the first set bit of req, searching
// rr_ptr, rr_ptr+1, ... and wrapping at NUM_REQ-1.
module rr_select #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [IDX_W-1:0]   winner,
  output logic               found
);

  logic [IDX_W:0] sum;

  // Walk the offsets from farthest to nearest so the nearest request wins.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    sum    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, rr_ptr} + (IDX_W + 1)'(k);
      if (sum >= (IDX_W + 1)'(NUM_REQ)) begin
        sum = sum - (IDX_W + 1)'(NUM_REQ);
      end
      if (req[sum[IDX_W-1:0]]) begin
        winner = sum[IDX_W-1:0];
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter that feeds one UART transmitter.
//
// Requester handshake: req_ready[i] is a combinational one-cycle accept,
// only ever raised while req_valid[i] is high; the byte and its last flag
// are taken on the clock edge that ends that cycle. A requester must hold
// valid, data and last stable until it sees ready. Once a requester wins,
// the grant stays with it until the byte flagged last has been sent.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int DATA_WIDTH    = UART_DATA_WIDTH,
  parameter int BUSY_WAIT_MAX = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         o_txdata,
  output logic                          o_tx_enable,
  input  logic                          i_tx_busy,
  output logic [NUM_REQ-1:0]            o_grant,
  output logic                          o_active,
  output logic                          o_timeout,
  output logic [2:0]                    o_state
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(BUSY_WAIT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_WAIT_MAX - 1);
  localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(NUM_REQ - 1);

  state_e                 state_q,     state_d;
  logic [IDX_W-1:0]       rr_ptr_q,    rr_ptr_d;
  logic [IDX_W-1:0]       owner_q,     owner_d;
  logic [NUM_REQ-1:0]     grant_q,     grant_d;
  logic                   active_q,    active_d;
  logic [DATA_WIDTH-1:0]  txdata_q,    txdata_d;
  logic                   tx_enable_q, tx_enable_d;
  logic                   timeout_q,   timeout_d;
  logic                   last_q,      last_d;
  logic [CNT_W-1:0]       cnt_q,       cnt_d;
  // Low for the first cycle after reset release so no accept can coincide
  // with the reset edge and req_ready stays low throughout reset.
  logic                   run_q,       run_d;

  logic [IDX_W-1:0]       rr_winner;
  logic                   rr_found;
  logic                   accept;
  logic [IDX_W-1:0]       acc_idx;

  rr_select #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_select (
    .req    (req_valid),
    .rr_ptr (rr_ptr_q),
    .winner (rr_winner),
    .found  (rr_found)
  );

  // Decide whether a byte is accepted this cycle and from whom.
  always_comb begin
    accept  = 1'b0;
    acc_idx = '0;
    case (state_q)
      ST_IDLE: begin
        if (run_q && rr_found) begin
          accept  = 1'b1;
          acc_idx = rr_winner;
        end
      end
      ST_NEXT: begin
        if (req_valid[owner_q]) begin
          accept  = 1'b1;
          acc_idx = owner_q;
        end
      end
      default: ;
    endcase
    req_ready = accept ? (NUM_REQ'(1) << acc_idx) : '0;
  end

  // Next-state and register updates for the transmit sequencer.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    grant_d     = grant_q;
    active_d    = active_q;
    txdata_d    = txdata_q;
    tx_enable_d = 1'b0;
    timeout_d   = 1'b0;
    last_d      = last_q;
    cnt_d       = cnt_q;
    run_d       = 1'b1;

    case (state_q)
      ST_IDLE, ST_NEXT: begin
        if (accept) begin
          txdata_d    = DATA_WIDTH'(req_data >> (int'(acc_idx) * DATA_WIDTH));
          last_d      = req_last[acc_idx];
          owner_d     = acc_idx;
          grant_d     = NUM_REQ'(1) << acc_idx;
          active_d    = 1'b1;
          tx_enable_d = 1'b1;
          state_d     = ST_START;
        end
      end
      ST_START: begin
        cnt_d   = '0;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (i_tx_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (cnt_q == CNT_LAST) begin
          // Transmitter never acknowledged; give up on this byte.
          timeout_d = 1'b1;
          state_d   = ST_END;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (!i_tx_busy) begin
          state_d = ST_END;
        end
      end
      ST_END: begin
        if (last_q) begin
          rr_ptr_d = (owner_q == IDX_MAX) ? '0 : owner_q + 1'b1;
          grant_d  = '0;
          active_d = 1'b0;
          state_d  = ST_IDLE;
        end else begin
          state_d = ST_NEXT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any transfer in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      grant_q     <= '0;
      active_q    <= 1'b0;
      txdata_q    <= '0;
      tx_enable_q <= 1'b0;
      timeout_q   <= 1'b0;
      last_q      <= 1'b0;
      cnt_q       <= '0;
      run_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      grant_q     <= grant_d;
      active_q    <= active_d;
      txdata_q    <= txdata_d;
      tx_enable_q <= tx_enable_d;
      timeout_q   <= timeout_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      run_q       <= run_d;
    end
  end

  assign o_txdata    = txdata_q;
  assign o_tx_enable = tx_enable_q;
  assign o_grant     = grant_q;
  assign o_active    = active_q;
  assign o_timeout   = timeout_q;
  assign o_state     = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: per-requester byte queues, a simple UART_TX
// busy model and a scoreboard of {requester, byte} in service order.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int NUM_REQ       = 4;
  localparam int DW            = 8;
  localparam int BUSY_WAIT_MAX = 16;
  localparam int BUSY_LEN      = 20;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*DW-1:0] req_data;
  logic [NUM_REQ-1:0]    req_last;
  logic [NUM_REQ-1:0]    req_ready;
  logic [DW-1:0]         o_txdata;
  logic                  o_tx_enable;
  logic                  i_tx_busy;
  logic [NUM_REQ-1:0]    o_grant;
  logic                  o_active;
  logic                  o_timeout;
  logic [2:0]            o_state;

  uart_tx_arbiter #(
    .NUM_REQ       (NUM_REQ),
    .DATA_WIDTH    (DW),
    .BUSY_WAIT_MAX (BUSY_WAIT_MAX)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .o_txdata    (o_txdata),
    .o_tx_enable (o_tx_enable),
    .i_tx_busy   (i_tx_busy),
    .o_grant     (o_grant),
    .o_active    (o_active),
    .o_timeout   (o_timeout),
    .o_state     (o_state)
  );

  // ---------------- bench state ----------------
  int n_vec, n_err;
  int cyc, n_enables, n_timeouts, n_accepts;
  int en_cyc, acc_cyc, end_cyc, last_gap;
  int mode;          // 0: normal busy model, 1: busy never rises, 2: busy_force
  logic busy_force;
  int busy_cnt;
  bit pend_busy;

  logic [8:0] src_q [NUM_REQ][$];  // {last, data}
  logic [9:0] exp_q[$];            // {requester, data}

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_txdata",  32'(o_txdata), 0);
    check_eq("rst_enable",  32'(o_tx_enable), 0);
    check_eq("rst_grant",   32'(o_grant), 0);
    check_eq("rst_active",  32'(o_active), 0);
    check_eq("rst_timeout", 32'(o_timeout), 0);
    check_eq("rst_ready",   32'(req_ready), 0);
    check_eq("rst_state",   32'(o_state), 32'(ST_IDLE));
  endtask

  function automatic bit srcs_empty();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (src_q[i].size() != 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  // ---------------- driver ----------------
  task automatic push_byte(input int r, input logic [7:0] d, input logic l);
    logic [1:0] ri;
    ri = r[1:0];
    src_q[r].push_back({l, d});
    exp_q.push_back({ri, d});
  endtask

  // One clock: observe at negedge, then update model and requesters after posedge.
  task automatic step();
    logic [NUM_REQ-1:0] acc;
    logic [9:0] e;
    logic [NUM_REQ-1:0] g;
    logic [8:0] f;
    @(negedge clk);
    acc = '0;
    if (o_tx_enable) begin
      n_enables++;
      en_cyc = cyc;
      check_eq("enable_latency", cyc - acc_cyc, 1);
      if (exp_q.size() == 0) begin
        check_eq("spurious_enable", 32'(o_tx_enable), 0);
      end else begin
        e = exp_q.pop_front();
        g = 4'b0001 << e[9:8];
        check_eq("txdata", 32'(o_txdata), 32'(e[7:0]));
        check_eq("grant",  32'(o_grant), 32'(g));
      end
      if (mode == 0) pend_busy = 1'b1;
    end
    if (o_timeout) begin
      n_timeouts++;
      check_eq("timeout_latency", cyc - en_cyc, BUSY_WAIT_MAX + 1);
    end
    if (o_state == ST_END) end_cyc = cyc;
    if (req_ready != '0) begin
      check_eq("ready_onehot", $countones(req_ready), 1);
      check_eq("ready_without_valid", 32'(req_ready & ~req_valid), 0);
      acc       = req_ready;
      acc_cyc   = cyc;
      last_gap  = cyc - end_cyc;
      n_accepts++;
    end
    @(posedge clk);
    cyc++;
    #1;
    // UART_TX busy model
    if (!rst) begin
      busy_cnt  = 0;
      pend_busy = 1'b0;
    end else if (pend_busy) begin
      busy_cnt  = BUSY_LEN;
      pend_busy = 1'b0;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end
    i_tx_busy = (mode == 2) ? busy_force : (busy_cnt != 0);
    // requesters: drop accepted byte, present the next one
    for (int i = 0; i < NUM_REQ; i++) begin
      if (acc[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
      if (src_q[i].size() != 0) begin
        f = src_q[i][0];
        req_valid[i]          = 1'b1;
        req_data[i*DW +: DW]  = f[7:0];
        req_last[i]           = f[8];
      end else begin
        req_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k;
    bit done;
    k = 0;
    done = 1'b0;
    while (!done && k < budget) begin
      step();
      k++;
      done = (exp_q.size() == 0) && srcs_empty() && (o_state == ST_IDLE) && !o_active;
    end
    check_eq(tag, 32'(done), 1);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) src_q[i].delete();
    exp_q.delete();
    req_valid = '0;
    repeat (2) step();
    rst = 1'b1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int a0, e0, t0, k;
    n_vec = 0; n_err = 0; cyc = 0;
    n_enables = 0; n_timeouts = 0; n_accepts = 0;
    en_cyc = 0; acc_cyc = 0; end_cyc = 0; last_gap = 0;
    mode = 0; busy_force = 1'b0; busy_cnt = 0; pend_busy = 1'b0;
    rst = 1'b0; req_valid = '0; req_data = '0; req_last = '0; i_tx_busy = 1'b0;

    // reset state, with a requester already waiting
    #1;
    check_reset_outputs();
    src_q[2].push_back({1'b1, 8'hEE});
    repeat (3) step();
    check_eq("rst_ready_with_valid", 32'(req_ready), 0);
    check_reset_outputs();
    src_q[2].delete();
    step();
    rst = 1'b1;

    // single byte from requester 0
    a0 = n_accepts; e0 = n_enables;
    push_byte(0, 8'h41, 1'b1);
    wait_done("single_done", 200);
    check_eq("single_accepts", n_accepts - a0, 1);
    check_eq("single_enables", n_enables - e0, 1);
    check_eq("single_grant_clear", 32'(o_grant), 0);

    // rr_ptr is now 1: requester 1 must beat requester 0
    push_byte(1, 8'h11, 1'b1);
    push_byte(0, 8'h10, 1'b1);
    wait_done("rr_done", 300);

    // full contention after reset: order 0,1,2,3,0
    do_reset();
    a0 = n_accepts; e0 = n_enables;
    push_byte(0, 8'hA0, 1'b1);
    push_byte(1, 8'hA1, 1'b1);
    push_byte(2, 8'hA2, 1'b1);
    push_byte(3, 8'hA3, 1'b1);
    push_byte(0, 8'hA4, 1'b1);
    wait_done("contention_done", 800);
    check_eq("contention_accepts", n_accepts - a0, 5);
    check_eq("contention_enables", n_enables - e0, 5);

    // packet lock: req0 two-byte packet holds off req1
    do_reset();
    push_byte(0, 8'h48, 1'b0);
    push_byte(0, 8'h49, 1'b1);
    push_byte(1, 8'h5A, 1'b1);
    wait_done("lock_done", 500);

    // busy never rises: one timeout, grant released
    mode = 1;
    t0 = n_timeouts;
    push_byte(2, 8'h33, 1'b1);
    wait_done("timeout_done", 200);
    check_eq("timeout_count", n_timeouts - t0, 1);
    check_eq("timeout_grant_clear", 32'(o_grant), 0);
    check_eq("timeout_active_clear", 32'(o_active), 0);
    mode = 0;

    // reset during WAIT_DONE of req1's first byte
    push_byte(1, 8'h61, 1'b0);
    push_byte(1, 8'h62, 1'b1);
    k = 0;
    while (o_state != ST_WAIT_DONE && k < 100) begin
      step();
      k++;
    end
    check_eq("reach_wait_done", 32'(o_state), 32'(ST_WAIT_DONE));
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs();
    for (int i = 0; i < NUM_REQ; i++) src_q[i].delete();
    exp_q.delete();
    a0 = n_accepts;
    push_byte(3, 8'h77, 1'b1);
    repeat (2) step();
    check_eq("midrst_ready_held", 32'(req_ready), 0);
    rst = 1'b1;
    wait_done("midrst_done", 200);
    check_eq("midrst_accepts", n_accepts - a0, 1);

    // stale busy: busy already high when the byte starts
    mode = 2;
    busy_force = 1'b1;
    step();
    e0 = n_enables; a0 = n_accepts;
    push_byte(0, 8'h21, 1'b0);
    push_byte(0, 8'h22, 1'b1);
    k = 0;
    while (n_enables == e0 && k < 50) begin
      step();
      k++;
    end
    repeat (5) step();
    check_eq("stale_single_enable", n_enables - e0, 1);
    check_eq("stale_wait_done", 32'(o_state), 32'(ST_WAIT_DONE));
    busy_force = 1'b0;
    mode = 0;
    k = 0;
    while (n_accepts - a0 < 2 && k < 50) begin
      step();
      k++;
    end
    check_eq("stale_second_accept", n_accepts - a0, 2);
    check_eq("stale_accept_gap", last_gap, 1);
    wait_done("stale_done", 200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // global time bound
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART_TX transmitter among NUM_REQ byte sources. Arbitration is round-robin at packet granularity.
- Each requester offers bytes with valid/ready and marks the final byte of a packet with last. The grant is locked to that requester until last is sent.
- Sequences UART_TX: loads i_txdata, pulses i_tx_enable, then tracks o_busy rise and fall before accepting the next byte.
- Sits between the RX echo / constant-character sources and uart_tx1 in the loopback top.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 8, byte width; must match UART_TX DATA_WIDTH.
- BUSY_WAIT_MAX, 16, maximum cycles to wait for i_tx_busy to rise after the enable pulse.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- req_valid  in  NUM_REQ  requester i has a byte.
- req_data  in  NUM_REQ*DATA_WIDTH  requester i byte at [i*DATA_WIDTH +: DATA_WIDTH].
- req_last  in  NUM_REQ  byte is the final byte of a packet.
- req_ready  out  NUM_REQ  one-cycle accept pulse to requester i.
- o_txdata  out  DATA_WIDTH  to UART_TX i_txdata; registered.
- o_tx_enable  out  1  to UART_TX i_tx_enable; one-cycle pulse.
- i_tx_busy  in  1  from UART_TX o_busy.
- o_grant  out  NUM_REQ  one-hot current owner; 0 when none.
- o_active  out  1  a packet is in progress.
- o_timeout  out  1  one-cycle pulse when busy never rose.

Behaviour:
- Reset (rst=0, async):
  - State IDLE, rr_ptr=0.
  - o_txdata=0, o_tx_enable=0, o_grant=0, o_active=0, o_timeout=0, req_ready=0.
  - Wait counter 0, last flag 0.
- Reset mid-operation aborts immediately. No enable is pulsed after reset release until a new accept.
- States and transitions:
  - IDLE: winner = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
    - If a winner exists: req_ready[winner]=1 combinationally this cycle.
    - At the edge: capture data into o_txdata and req_last into the last flag; o_grant=onehot(winner); o_active=1; go to START.
  - START: o_tx_enable=1 for exactly this cycle; clear counter; go to WAIT_BUSY.
  - WAIT_BUSY: go to WAIT_DONE when i_tx_busy=1.
    - Otherwise increment the counter.
    - When counter==BUSY_WAIT_MAX-1 and busy is still 0: pulse o_timeout next cycle and proceed as if the byte completed (to END).
  - WAIT_DONE: go to END when i_tx_busy=0.
  - END (1 cycle):
    - last flag=1: rr_ptr=(owner+1) mod NUM_REQ, o_grant=0, o_active=0, go to IDLE.
    - last flag=0: go to NEXT.
  - NEXT (locked): only the owner is considered.
    - If req_valid[owner]=1: req_ready[owner]=1 combinationally; capture as in IDLE; go to START.
    - Other requesters are ignored. This wait is indefinite by design and the owner must complete its packet.
- Latency: the accept edge is T; o_tx_enable is high during cycle T+1. The next accept is no earlier than 1 cycle after busy falls (END, then IDLE/NEXT).
- req_ready is never asserted outside IDLE/NEXT. It is never asserted to more than one requester, and never to a requester with req_valid=0.
- Simultaneous valids in IDLE: the round-robin winner takes the grant; losers hold valid and data stable.
- i_tx_busy already 1 at START (stale): WAIT_BUSY sees 1 and WAIT_DONE waits for the fall. This is accepted behaviour.
- req_data/req_last are sampled only at the accept edge; changes at other times are ignored.
- rr_ptr wraps NUM_REQ-1 → 0.

Decomposition:
- Shared package uart_pkg:
  - state enum (IDLE, START, WAIT_BUSY, WAIT_DONE, END, NEXT).
  - UART_DATA_WIDTH=8, BAUD_RATE=9600, CLK_FREQ=100_000_000.
- Sub-module rr_select (combinational): inputs req vector and rr_ptr; outputs winner index and found flag.
- FSM, counter and data register stay in uart_tx_arbiter.

Test Plan (UART_TX model: busy rises 1 cycle after enable and stays high 20 cycles unless stated):
- Single byte: req_valid[0]=1, data 0x41, last=1.
  - Expected: ready[0] pulses once; enable high the next cycle with o_txdata=0x41; grant 0001 until END; rr_ptr becomes 1.
- Contention: all four valid, last=1, after reset.
  - Expected: service order 0,1,2,3,0; exactly one enable per byte; no ready overlap.
- Packet lock: req0 sends 0x48,0x49 (last on 0x49) while req1 valid with 0x5A throughout.
  - Expected: output 0x48,0x49,0x5A; req1 not granted until after 0x49's END.
- Busy timeout: model never asserts busy, req2 sends 0x33 last=1.
  - Expected: o_timeout pulses once, BUSY_WAIT_MAX+1 cycles after the enable; return to IDLE; grant cleared.
- Reset mid-packet: assert rst=0 during WAIT_DONE of req1's first byte.
  - Expected: all outputs 0 asynchronously.
  - After release with req3 valid: req3 granted first (rr_ptr=0 → search 0..3, only 3 valid).
- Stale busy: hold i_tx_busy=1 when START occurs, drop it 5 cycles later.
  - Expected: no second enable before END; next byte accepted 1 cycle after END.
